control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have the parameter OPW, default 3, meaning the opcode width taken from IR[7:5].
REQ-002 The module SHALL have the port clk, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have the port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have the port opcode, input, OPW bits: IR[7:5] from the instruction register.
REQ-005 The module SHALL have the port Aeq0, input, 1 bit: datapath status, A == 0.
REQ-006 The module SHALL have the port Apos, input, 1 bit: datapath status, A[7] == 0.
REQ-007 The module SHALL have the port Enter, input, 1 bit: operator strobe that completes an INPUT instruction.
REQ-008 The module SHALL have the port IRload, output, 1 bit: load the instruction register from memory.
REQ-009 The module SHALL have the port JMPmux, output, 1 bit: PC source select, 0 = PC+1, 1 = IR[4:0].
REQ-010 The module SHALL have the port PCload, output, 1 bit: load the PC.
REQ-011 The module SHALL have the port PCclear, output, 1 bit: PC <- 0.
REQ-012 The module SHALL have the port Meminst, output, 1 bit: memory address source, 1 = PC, 0 = IR[4:0].
REQ-013 The module SHALL have the port MemWr, output, 1 bit: memory write strobe (data = A).
REQ-014 The module SHALL have the port Asel, output, 2 bits: accumulator mux select; 0 = add/sub result, 1 = Input, 2 = memory/IR data, 3 = GND (zero).
REQ-015 The module SHALL have the port loadA, output, 1 bit: accumulator load enable.
REQ-016 The module SHALL have the port sub, output, 1 bit: add/sub unit mode, 1 = subtract.
REQ-017 The module SHALL have the port Halt, output, 1 bit: processor halted.

Function
REQ-018 The module SHALL implement a single state register with the states START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS, HALT.
REQ-019 Every output SHALL be 0 unless this section asserts it; outputs SHALL be decoded from the current state, Mealy only where stated.
REQ-020 START SHALL assert PCclear=1, Asel=3 and loadA=1 (A <- 0), then go to FETCH next cycle.
REQ-021 FETCH SHALL assert Meminst=1, IRload=1, PCload=1 and JMPmux=0, then go to DECODE.
REQ-022 DECODE SHALL assert Meminst=0 and select the next state by opcode: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-023 LOAD SHALL assert Asel=2 and loadA=1, then go to FETCH.
REQ-024 STORE SHALL assert MemWr=1 with Meminst=0, then go to FETCH.
REQ-025 ADD SHALL assert Asel=0, sub=0 and loadA=1; SUB SHALL assert Asel=0, sub=1 and loadA=1; both SHALL go to FETCH; overflow is ignored and wraps modulo 2^8 in the datapath.
REQ-026 INPUT SHALL assert Asel=1 every cycle, assert loadA=Enter (Mealy), stay in INPUT while Enter=0, and go to FETCH on the cycle Enter=1.
REQ-027 JZ SHALL assert JMPmux=1 and PCload=Aeq0 (Mealy), then go to FETCH regardless of Aeq0.
REQ-028 JPOS SHALL assert JMPmux=1 and PCload=Apos (Mealy), then go to FETCH regardless of Apos.
REQ-029 HALT SHALL assert Halt=1 and remain in HALT until reset; Enter SHALL be ignored in HALT.
REQ-030 Instruction latency SHALL be 3 cycles (FETCH, DECODE, execute), except INPUT, which takes 2 + N cycles where N is the number of cycles up to and including the one with Enter=1.
REQ-031 An unreachable state encoding SHALL go to START on the next edge.

Reset
REQ-032 reset=1 at a rising edge SHALL force the state to START from any state, including mid-INPUT and HALT, and SHALL take priority over every other transition.
REQ-033 While the state is START, outputs SHALL be exactly the START outputs; no other reset value is permitted.

Structure
REQ-034 The state enumeration, the opcode constants (OP_LOAD..OP_HALT) and the Asel codes (ASEL_ADDSUB=0, ASEL_INPUT=1, ASEL_MEM=2, ASEL_GND=3) SHALL live in a shared package also used by the datapath.
REQ-035 The module SHALL be a single module with no sub-module: a state register plus next-state and output decode.

Verification
REQ-036 Reset sequence: reset=1 for 1 edge, then 0 -> START for 1 cycle (PCclear=1, Asel=3, loadA=1), then FETCH (IRload=PCload=Meminst=1), then DECODE.
REQ-037 ADD with opcode=010 -> DECODE then ADD with Asel=0, sub=0, loadA=1, back in FETCH 3 cycles after the first FETCH; SUB with opcode=011 -> sub=1.
REQ-038 INPUT with Enter held 0 for 4 cycles, then 1 -> INPUT for 5 cycles with loadA=0 for 4 and loadA=1 on the 5th, then FETCH.
REQ-039 JZ with Aeq0=1 -> JMPmux=1, PCload=1; JZ with Aeq0=0 -> JMPmux=1, PCload=0; JPOS with Apos=1/0 -> PCload=1/0; all return to FETCH.
REQ-040 HALT with opcode=111 -> Halt=1 held for 10 cycles with Enter toggling; then reset=1 -> START on the next edge.
REQ-041 Reset mid-operation: reset=1 during INPUT and during STORE -> START on the next edge with MemWr=0 and loadA from START only.

Source files
------------

// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the accumulator CPU control unit and its datapath:
//   - state_t      : control FSM state encoding
//   - OP_*         : opcode field values (IR[7:5])
//   - ASEL_*       : accumulator input mux select codes
//   - decode_op()  : maps an opcode to the execute state it dispatches to
// -----------------------------------------------------------------------------
package control_unit_pkg;

    localparam int OPW_DEFAULT = 3;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ADDSUB = 2'd0;
    localparam logic [1:0] ASEL_INPUT  = 2'd1;
    localparam logic [1:0] ASEL_MEM    = 2'd2;
    localparam logic [1:0] ASEL_GND    = 2'd3;

    // Every 3-bit opcode names an instruction, so this mapping is total.
    function automatic state_t decode_op(input logic [2:0] op);
        state_t st;
        case (op)
            OP_LOAD:  st = S_LOAD;
            OP_STORE: st = S_STORE;
            OP_ADD:   st = S_ADD;
            OP_SUB:   st = S_SUB;
            OP_INPUT: st = S_INPUT;
            OP_JZ:    st = S_JZ;
            OP_JPOS:  st = S_JPOS;
            default:  st = S_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
// Bundle between the control unit and the datapath.
//   Status  (datapath -> control): opcode[OPW-1:0], Aeq0, Apos, Enter
//   Control (control -> datapath): IRload, JMPmux, PCload, PCclear, Meminst,
//                                  MemWr, Asel[1:0], loadA, sub, Halt
// Modports:
//   master : the control unit (drives control, reads status)
//   slave  : the datapath     (drives status, reads control)
// -----------------------------------------------------------------------------
interface control_unit_if #(
    parameter int OPW = 3
);
    logic [OPW-1:0] opcode;
    logic           Aeq0;
    logic           Apos;
    logic           Enter;

    logic           IRload;
    logic           JMPmux;
    logic           PCload;
    logic           PCclear;
    logic           Meminst;
    logic           MemWr;
    logic [1:0]     Asel;
    logic           loadA;
    logic           sub;
    logic           Halt;

    modport master (
        input  opcode, Aeq0, Apos, Enter,
        output IRload, JMPmux, PCload, PCclear, Meminst, MemWr,
               Asel, loadA, sub, Halt
    );

    modport slave (
        output opcode, Aeq0, Apos, Enter,
        input  IRload, JMPmux, PCload, PCclear, Meminst, MemWr,
               Asel, loadA, sub, Halt
    );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Control FSM of a small accumulator CPU. A single state register walks
// START -> FETCH -> DECODE -> <execute> -> FETCH ..., with HALT terminal until
// reset. Outputs are decoded from the current state; only INPUT (loadA=Enter),
// JZ (PCload=Aeq0) and JPOS (PCload=Apos) have Mealy terms.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces START from any state
//   bus   : control_unit_if.master (status in, control strobes out)
// -----------------------------------------------------------------------------
module control_unit
    import control_unit_pkg::*;
#(
    parameter int OPW = OPW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    control_unit_if.master  bus
);

    state_t state_q;
    state_t state_d;

    // The instruction set only defines the low three opcode bits.
    logic [OPW-1:0] opcode_w;
    logic [2:0]     op_field;
    assign opcode_w = bus.opcode;
    assign op_field = opcode_w[2:0];

    // State register; reset wins over every other transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = S_START;
        bus.IRload  = 1'b0;
        bus.JMPmux  = 1'b0;
        bus.PCload  = 1'b0;
        bus.PCclear = 1'b0;
        bus.Meminst = 1'b0;
        bus.MemWr   = 1'b0;
        bus.Asel    = ASEL_ADDSUB;
        bus.loadA   = 1'b0;
        bus.sub     = 1'b0;
        bus.Halt    = 1'b0;

        case (state_q)
            S_START: begin
                // Clear PC and accumulator together.
                bus.PCclear = 1'b1;
                bus.Asel    = ASEL_GND;
                bus.loadA   = 1'b1;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                // IR <- mem[PC] and PC <- PC+1 on the same edge.
                bus.Meminst = 1'b1;
                bus.IRload  = 1'b1;
                bus.PCload  = 1'b1;
                bus.JMPmux  = 1'b0;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Address switches to IR[4:0] so LOAD sees its operand.
                bus.Meminst = 1'b0;
                state_d     = decode_op(op_field);
            end
            S_LOAD: begin
                bus.Asel  = ASEL_MEM;
                bus.loadA = 1'b1;
                state_d   = S_FETCH;
            end
            S_STORE: begin
                bus.Meminst = 1'b0;
                bus.MemWr   = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADD: begin
                bus.Asel  = ASEL_ADDSUB;
                bus.sub   = 1'b0;
                bus.loadA = 1'b1;
                state_d   = S_FETCH;
            end
            S_SUB: begin
                bus.Asel  = ASEL_ADDSUB;
                bus.sub   = 1'b1;
                bus.loadA = 1'b1;
                state_d   = S_FETCH;
            end
            S_INPUT: begin
                // Mux held on the input port; A captures only on the Enter cycle.
                bus.Asel  = ASEL_INPUT;
                bus.loadA = bus.Enter;
                state_d   = bus.Enter ? S_FETCH : S_INPUT;
            end
            S_JZ: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Aeq0;
                state_d    = S_FETCH;
            end
            S_JPOS: begin
                bus.JMPmux = 1'b1;
                bus.PCload = bus.Apos;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                bus.Halt = 1'b1;
                state_d  = S_HALT;
            end
            default: begin
                // Illegal encodings recover through START.
                state_d = S_START;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    control_unit_if #(.OPW(3)) bus ();

    control_unit #(.OPW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {IRload,JMPmux,PCload,PCclear,Meminst,MemWr,Asel,loadA,sub,Halt}
    logic [10:0] obs;
    assign obs = {bus.IRload, bus.JMPmux, bus.PCload, bus.PCclear, bus.Meminst,
                  bus.MemWr, bus.Asel, bus.loadA, bus.sub, bus.Halt};

    function automatic logic [10:0] ov(input logic irl, input logic jmp,
                                       input logic pcl, input logic pcc,
                                       input logic mi, input logic mw,
                                       input logic [1:0] as, input logic la,
                                       input logic sb, input logic h);
        return {irl, jmp, pcl, pcc, mi, mw, as, la, sb, h};
    endfunction

    logic [10:0] e_start, e_fetch, e_decode, e_load, e_store, e_add, e_sub;
    logic [10:0] e_in0, e_in1, e_jmp0, e_jmp1, e_halt;

    task automatic chk(input string tag, input logic [10:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
        $display("check %-14s observed=%b expected=%b", tag, obs, exp_v);
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH (already checked); runs DECODE, execute, back to FETCH.
    task automatic run_instr(input logic [2:0] op, input string tag,
                             input logic [10:0] exp_exec);
        bus.opcode = op;
        adv(); chk({tag, "_dec"}, e_decode);
        adv(); chk(tag, exp_exec);
        adv(); chk({tag, "_fetch"}, e_fetch);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        e_start  = ov(0,0,0,1,0,0,2'd3,1,0,0);
        e_fetch  = ov(1,0,1,0,1,0,2'd0,0,0,0);
        e_decode = ov(0,0,0,0,0,0,2'd0,0,0,0);
        e_load   = ov(0,0,0,0,0,0,2'd2,1,0,0);
        e_store  = ov(0,0,0,0,0,1,2'd0,0,0,0);
        e_add    = ov(0,0,0,0,0,0,2'd0,1,0,0);
        e_sub    = ov(0,0,0,0,0,0,2'd0,1,1,0);
        e_in0    = ov(0,0,0,0,0,0,2'd1,0,0,0);
        e_in1    = ov(0,0,0,0,0,0,2'd1,1,0,0);
        e_jmp0   = ov(0,1,0,0,0,0,2'd0,0,0,0);
        e_jmp1   = ov(0,1,1,0,0,0,2'd0,0,0,0);
        e_halt   = ov(0,0,0,0,0,0,2'd0,0,0,1);

        reset      = 1'b1;
        bus.opcode = OP_LOAD;
        bus.Aeq0   = 1'b0;
        bus.Apos   = 1'b0;
        bus.Enter  = 1'b0;

        // Reset sequence
        adv(); reset = 1'b0; #1; chk("start", e_start);
        adv(); chk("fetch", e_fetch);

        // Arithmetic and memory instructions
        run_instr(OP_ADD,   "add",   e_add);
        run_instr(OP_SUB,   "sub",   e_sub);
        run_instr(OP_LOAD,  "load",  e_load);
        run_instr(OP_STORE, "store", e_store);

        // Conditional jumps, both outcomes
        bus.Aeq0 = 1'b1; run_instr(OP_JZ,   "jz1",   e_jmp1);
        bus.Aeq0 = 1'b0; run_instr(OP_JZ,   "jz0",   e_jmp0);
        bus.Apos = 1'b1; run_instr(OP_JPOS, "jpos1", e_jmp1);
        bus.Apos = 1'b0; run_instr(OP_JPOS, "jpos0", e_jmp0);
        // Aeq0 set must not leak into JPOS
        bus.Aeq0 = 1'b1; run_instr(OP_JPOS, "jpos0z", e_jmp0);
        bus.Aeq0 = 1'b0;

        // INPUT: four waiting cycles, then Enter on the fifth
        bus.opcode = OP_INPUT;
        bus.Enter  = 1'b0;
        adv(); chk("in_dec", e_decode);
        for (int i = 0; i < 4; i++) begin
            adv(); chk("in_wait", e_in0);
        end
        adv(); bus.Enter = 1'b1; #1; chk("in_enter", e_in1);
        adv(); bus.Enter = 1'b0; #1; chk("in_fetch", e_fetch);

        // Reset in the middle of INPUT, with Enter asserted on that edge
        adv(); chk("inr_dec", e_decode);
        adv(); chk("inr_wait", e_in0);
        bus.Enter = 1'b1; reset = 1'b1; #1; chk("inr_enter", e_in1);
        adv(); reset = 1'b0; bus.Enter = 1'b0; #1; chk("inr_start", e_start);
        adv(); chk("inr_fetch", e_fetch);

        // Reset in the middle of STORE
        bus.opcode = OP_STORE;
        adv(); chk("str_dec", e_decode);
        adv(); chk("str_exec", e_store);
        reset = 1'b1;
        adv(); reset = 1'b0; #1; chk("str_start", e_start);
        adv(); chk("str_fetch", e_fetch);

        // HALT ignores Enter for ten cycles, exits only through reset
        bus.opcode = OP_HALT;
        adv(); chk("halt_dec", e_decode);
        for (int i = 0; i < 10; i++) begin
            adv(); bus.Enter = ~bus.Enter; #1; chk("halt_hold", e_halt);
        end
        bus.Enter = 1'b0;
        reset = 1'b1;
        adv(); reset = 1'b0; #1; chk("halt_start", e_start);
        adv(); chk("halt_fetch", e_fetch);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
